// File: rtl/regfile_pkg.sv
// Shared defaults and address helpers for the multi-port register file.
package regfile_pkg;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned ZERO_ADDR = 0;

  function automatic logic addr_valid(input logic [31:0] addr, input int unsigned nreg);
    return addr < nreg;
  endfunction
endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: selects the stored value or the highest-priority same-cycle write.
// Purely combinational; hit_o tells the top that the port is being forwarded.
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NREG     = 32,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [XLEN-1:0]     stored_i,
  input  logic [AW-1:0]       ra_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   wa_i,
  input  logic [NWR*XLEN-1:0] wd_i,
  input  logic                rst_n_i,
  output logic [XLEN-1:0]     rd_o,
  output logic                hit_o
);
  logic fwd_ok;

  always_comb begin
    fwd_ok = (BYPASS != 0) && rst_n_i && addr_valid(32'(ra_i), NREG)
             && !((ZERO_REG != 0) && (32'(ra_i) == ZERO_ADDR));
    rd_o   = stored_i;
    hit_o  = 1'b0;
    // Ascending scan so the highest matching port index is the last assignment.
    for (int j = 0; j < NWR; j++) begin
      if (fwd_ok && we_i[j] && (wa_i[j*AW +: AW] == ra_i)) begin
        rd_o  = wd_i[j*XLEN +: XLEN];
        hit_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with priority writes, bypass and busy scoreboard.
// Reads are combinational; writes and reservations land on the rising edge.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_a,
  output logic [NRD-1:0]      busy,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  function automatic logic writable(input logic [AW-1:0] a);
    return addr_valid(32'(a), NREG) && !((ZERO_REG != 0) && (32'(a) == ZERO_ADDR));
  endfunction

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && writable(wa[j*AW +: AW])) begin
        mem_d[wa[j*AW +: AW]]  = wd[j*XLEN +: XLEN];
        busy_d[wa[j*AW +: AW]] = 1'b0;
      end
    end
    // Reserve after writes: a new producer outranks the retiring one.
    if (rsv_en && writable(rsv_a)) begin
      busy_d[rsv_a] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra_l;
    logic            ra_ok;
    logic [XLEN-1:0] stored;
    logic            hit;

    assign ra_l   = ra[i*AW +: AW];
    assign ra_ok  = addr_valid(32'(ra_l), NREG);
    assign stored = ra_ok ? mem_q[ra_l] : '0;

    regfile_fwd_mux #(
      .XLEN(XLEN), .AW(AW), .NREG(NREG), .NWR(NWR),
      .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_fwd (
      .stored_i(stored),
      .ra_i    (ra_l),
      .we_i    (we),
      .wa_i    (wa),
      .wd_i    (wd),
      .rst_n_i (rst_n),
      .rd_o    (rd[i*XLEN +: XLEN]),
      .hit_o   (hit)
    );

    assign busy[i] = ra_ok && busy_q[ra_l] && !hit;
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: instance A uses defaults (bypass on, 32 regs); instance B has
// bypass off and 12 registers so out-of-range addresses exist.
module tb_register_file_mp;
  logic clk;
  logic rst_n;

  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic [1:0]  we_a;
  logic [9:0]  wa_a;
  logic [63:0] wd_a;
  logic        rsv_en_a;
  logic [4:0]  rsv_a_a;
  logic [1:0]  busy_a;
  logic [31:0] bv_a;

  logic [7:0]  ra_b;
  logic [63:0] rd_b;
  logic [1:0]  we_b;
  logic [7:0]  wa_b;
  logic [63:0] wd_b;
  logic        rsv_en_b;
  logic [3:0]  rsv_a_b;
  logic [1:0]  busy_b;
  logic [11:0] bv_b;

  int errors = 0;
  int checks = 0;

  register_file_mp u_a (
    .clk(clk), .rst_n(rst_n), .ra(ra_a), .rd(rd_a), .we(we_a), .wa(wa_a), .wd(wd_a),
    .rsv_en(rsv_en_a), .rsv_a(rsv_a_a), .busy(busy_a), .busy_vec(bv_a)
  );

  register_file_mp #(.NREG(12), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ra(ra_b), .rd(rd_b), .we(we_b), .wa(wa_b), .wd(wd_b),
    .rsv_en(rsv_en_b), .rsv_a(rsv_a_b), .busy(busy_b), .busy_vec(bv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ra_a = '0; we_a = '0; wa_a = '0; wd_a = '0; rsv_en_a = 1'b0; rsv_a_a = '0;
    ra_b = '0; we_b = '0; wa_b = '0; wd_b = '0; rsv_en_b = 1'b0; rsv_a_b = '0;
    tick();
    chk("reset_rd_a", rd_a, 64'h0);
    chk("reset_busy_a", {62'h0, busy_a}, 64'h0);
    chk("reset_bv_a", {32'h0, bv_a}, 64'h0);
    chk("reset_bv_b", {52'h0, bv_b}, 64'h0);
    rst_n = 1'b1;

    // r5 <= FFFFFFFF, then reset with a conflicting write and reservation
    we_a = 2'b01; wa_a[4:0] = 5'd5; wd_a[31:0] = 32'hFFFF_FFFF;
    tick();
    we_a = 2'b00; ra_a[4:0] = 5'd5;
    #1;
    chk("r5_written", {32'h0, rd_a[31:0]}, 64'hFFFF_FFFF);
    rst_n = 1'b0;
    we_a = 2'b01; wd_a[31:0] = 32'h0000_0077; rsv_en_a = 1'b1; rsv_a_a = 5'd6;
    #1;
    chk("no_bypass_in_reset", {32'h0, rd_a[31:0]}, 64'hFFFF_FFFF);
    tick();
    rst_n = 1'b1; we_a = 2'b00; rsv_en_a = 1'b0;
    #1;
    chk("r5_cleared", {32'h0, rd_a[31:0]}, 64'h0);
    chk("bv_after_reset", {32'h0, bv_a}, 64'h0);

    // Dual-write collision on r3: port 1 wins
    we_a = 2'b11; wa_a = {5'd3, 5'd3}; wd_a = {32'h0000_00BB, 32'h0000_00AA}; ra_a[4:0] = 5'd3;
    #1;
    chk("collision_bypass", {32'h0, rd_a[31:0]}, 64'hBB);
    tick();
    we_a = 2'b00;
    #1;
    chk("collision_stored", {32'h0, rd_a[31:0]}, 64'hBB);

    // x0 protection
    we_a = 2'b01; wa_a[4:0] = 5'd0; wd_a[31:0] = 32'hDEAD_BEEF;
    rsv_en_a = 1'b1; rsv_a_a = 5'd0; ra_a[9:5] = 5'd0;
    #1;
    chk("x0_no_bypass", {32'h0, rd_a[63:32]}, 64'h0);
    tick();
    we_a = 2'b00; rsv_en_a = 1'b0;
    #1;
    chk("x0_reads_zero", {32'h0, rd_a[63:32]}, 64'h0);
    chk("x0_not_busy", {32'h0, bv_a}, 64'h0);

    // Disabled write leaves r1 alone
    we_a = 2'b01; wa_a[4:0] = 5'd1; wd_a[31:0] = 32'h0000_00AA;
    tick();
    we_a = 2'b00; wd_a[31:0] = 32'h1111_1111; ra_a[4:0] = 5'd1;
    tick();
    chk("we_off_keeps", {32'h0, rd_a[31:0]}, 64'hAA);

    // Scoreboard on r9
    rsv_en_a = 1'b1; rsv_a_a = 5'd9; ra_a[9:5] = 5'd9;
    #1;
    chk("rsv_not_yet", {62'h0, busy_a}, 64'h0);
    tick();
    rsv_en_a = 1'b0;
    #1;
    chk("rsv_busy", {63'h0, busy_a[1]}, 64'h1);
    chk("rsv_bv", {32'h0, bv_a}, 64'h200);
    we_a = 2'b10; wa_a[9:5] = 5'd9; wd_a[63:32] = 32'h0000_0055;
    #1;
    chk("wr_busy_masked", {63'h0, busy_a[1]}, 64'h0);
    chk("wr_fwd_data", {32'h0, rd_a[63:32]}, 64'h55);
    chk("wr_bv_unchanged", {32'h0, bv_a}, 64'h200);
    tick();
    we_a = 2'b00;
    #1;
    chk("wr_bv_cleared", {32'h0, bv_a}, 64'h0);
    chk("wr_r9_stored", {32'h0, rd_a[63:32]}, 64'h55);

    // Reserve and write r9 together: reserve wins, data lands
    rsv_en_a = 1'b1; rsv_a_a = 5'd9; we_a = 2'b01; wa_a[4:0] = 5'd9; wd_a[31:0] = 32'h0000_0066;
    tick();
    rsv_en_a = 1'b0; we_a = 2'b00;
    #1;
    chk("rsv_wr_bv", {32'h0, bv_a}, 64'h200);
    chk("rsv_wr_data", {32'h0, rd_a[63:32]}, 64'h66);
    chk("rsv_wr_busy", {63'h0, busy_a[1]}, 64'h1);

    // Independent writes on both ports
    we_a = 2'b11; wa_a = {5'd11, 5'd10}; wd_a = {32'h0000_0002, 32'h0000_0001};
    tick();
    we_a = 2'b00; ra_a = {5'd11, 5'd10};
    #1;
    chk("dual_r10", {32'h0, rd_a[31:0]}, 64'h1);
    chk("dual_r11", {32'h0, rd_a[63:32]}, 64'h2);

    // Instance B: no bypass
    we_b = 2'b01; wa_b[3:0] = 4'd7; wd_b[31:0] = 32'h0000_1234; ra_b[3:0] = 4'd7;
    #1;
    chk("nobyp_old", {32'h0, rd_b[31:0]}, 64'h0);
    tick();
    we_b = 2'b00;
    #1;
    chk("nobyp_new", {32'h0, rd_b[31:0]}, 64'h1234);

    // Out-of-range address 13 with 12 registers
    we_b = 2'b10; wa_b[7:4] = 4'd13; wd_b[63:32] = 32'h0000_CAFE;
    rsv_en_b = 1'b1; rsv_a_b = 4'd13; ra_b[7:4] = 4'd13;
    tick();
    we_b = 2'b00; rsv_en_b = 1'b0;
    #1;
    chk("oor_rd", {32'h0, rd_b[63:32]}, 64'h0);
    chk("oor_busy", {63'h0, busy_b[1]}, 64'h0);
    chk("oor_bv", {52'h0, bv_b}, 64'h0);

    // Without bypass a same-cycle write does not mask busy
    rsv_en_b = 1'b1; rsv_a_b = 4'd2;
    tick();
    rsv_en_b = 1'b0; we_b = 2'b01; wa_b[3:0] = 4'd2; wd_b[31:0] = 32'h0000_0009; ra_b[7:4] = 4'd2;
    #1;
    chk("nobyp_busy_held", {63'h0, busy_b[1]}, 64'h1);
    tick();
    we_b = 2'b00;
    #1;
    chk("nobyp_bv_cleared", {52'h0, bv_b}, 64'h0);
    chk("nobyp_r2", {32'h0, rd_b[63:32]}, 64'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the next core generation (pipelined / dual-issue datapath), superseding the single-write, two-read `register_file`. It provides NRD combinational read ports, NWR synchronous write ports with fixed priority, optional same-cycle write-to-read bypass, a hardwired-zero x0, a synchronous clear-on-reset, and a per-register busy scoreboard for hazard detection in decode.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers
- NRD, 2, read port count
- NWR, 2, write port count; a higher index has higher priority
- BYPASS, 1, 1 = forward same-cycle write data to reads; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero
- AW, derived as $clog2(NREG), address width (localparam)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- ra  in  NRD*AW  read addresses, port i in bits [i*AW +: AW]
- rd  out  NRD*XLEN  read data, port i in bits [i*XLEN +: XLEN]
- we  in  NWR  write enables
- wa  in  NWR*AW  write addresses
- wd  in  NWR*XLEN  write data
- rsv_en  in  1  reserve (mark busy) the register at rsv_a
- rsv_a  in  AW  register to reserve
- busy  out  NRD  busy flag for each read address
- busy_vec  out  NREG  full scoreboard state

## Operation
- Storage is NREG x XLEN flops. Register 0 (ZERO_REG=1): writes and reservations are ignored, it reads 0, and it is never busy.
- Writes: at the posedge, for each j with we[j]=1, mem[wa_j] <= wd_j. When several ports target the same address, the highest index wins.
- Reads are combinational: rd_i = mem[ra_i].
- With BYPASS=1, if any active write port has wa_j == ra_i (and the address is non-zero and valid), rd_i = wd of the highest-index matching port.
- Out-of-range addresses (>= NREG, when NREG is not a power of two): writes and reservations are ignored; reads return 0 with busy 0.
- Scoreboard:
  - busy_vec[r] sets on rsv_en with rsv_a=r.
  - busy_vec[r] clears on any write to r.
  - Reserve and write to the same r in one cycle: the reserve wins (busy stays 1, the new producer is pending) and the data is still written.
- busy[i] = busy_vec[ra_i]. With BYPASS=1 it is forced to 0 when an active write hits ra_i in the same cycle, because that data is forwarded.
- Reset: any posedge with rst_n=0 clears all mem entries and busy_vec to 0. Writes and reservations in that cycle are discarded, and bypass is suppressed while rst_n=0.

## Timing
- Write latency: stored value visible on rd one cycle after the write posedge. Bypass path has zero-cycle latency.
- Reservation is visible on busy and busy_vec the cycle after rsv_en.
- Reset values after the first reset edge: every rd = 0, busy = 0, busy_vec = 0.
- Reset asserted mid-operation: state is cleared on that edge regardless of we or rsv_en. Deassertion takes effect on the next edge; no warm-up cycle.
- Combinational paths run from ra/wa/we/wd/rst_n to rd and busy. There is no path from inputs to busy_vec.

## Structure
- Package regfile_pkg holds:
  - XLEN_DEF and NREG_DEF
  - ZERO_ADDR constant
  - function addr_valid(addr, nreg)
- Sub-module regfile_fwd_mux, instantiated NRD times:
  - inputs: stored value, ra, we/wa/wd vectors, rst_n
  - outputs: the priority-forwarded rd and the write-hit flag used to mask busy
- The top level holds the storage array, the write-priority loop and the scoreboard flops.

## Test plan
- Reset then idle: hold rst_n=0 for 1 edge after writing 0xFFFFFFFF to r5 -> rd(r5)=0 and busy_vec=0 after the edge.
- Dual-write collision: we=2'b11, wa0=wa1=3, wd0=0xAA, wd1=0xBB -> r3=0xBB next cycle; with BYPASS=1, same-cycle rd(ra=3)=0xBB.
- Bypass off (BYPASS=0): write 0x1234 to r7 while ra0=7 -> rd0 shows the old value (0) that cycle and 0x1234 the next.
- x0 protection: write 0xDEADBEEF to r0 plus rsv_en on r0 -> rd(r0)=0 and busy_vec[0]=0.
- Scoreboard:
  - rsv_en on r9 -> busy=1 the next cycle for ra=9.
  - Write 0x55 to r9 -> busy=0 in the same cycle (bypass) and busy_vec[9]=0 after the edge.
  - Simultaneous reserve and write to r9 -> busy_vec[9]=1 and r9=new data.
- Write disabled: we=0 with wa=1, wd=0x11111111 -> r1 keeps its prior value 0xAA.
